// File: rtl/elevator_pkg.sv
// elevator_pkg: shared call types for the hall-call generator and its FIFO.
//   dir_t  : call direction (DIR_UP / DIR_DN)
//   call_t : one hall call {floor, dir}
package elevator_pkg;
    localparam int FLOOR_W = 4;
    typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_t;
    typedef struct packed {
        logic [FLOOR_W-1:0] floor;
        dir_t               dir;
    } call_t;
endpackage

// File: rtl/call_request_gen_fifo.sv
// call_fifo: synchronous FIFO with registered storage; head is read straight from the array.
//   clk, rst    : clock, asynchronous active-high reset
//   push, din   : write request and data (taken when not full, or when full and popping)
//   pop         : read request (ignored when empty)
//   dout        : head entry
//   full, empty : occupancy flags
module call_fifo
    import elevator_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = call_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/call_request_gen.sv
// call_request_gen: turns rng words into paced, deduplicated hall calls queued for the dispatcher.
//   clk, rst                        : clock, asynchronous active-high reset
//   randy[11:0]                     : random word (press = [11:8], floor = [7:4], dir = [0])
//   enable                          : run the sampling prescaler
//   req_valid/req_floor/req_dir     : FIFO head call, popped on req_valid && req_ready
//   req_ready                       : dispatcher accepts the head call
//   svc_valid/svc_floor/svc_dir     : dispatcher reports a serviced call (clears pending bit)
//   pending_up/pending_dn           : per-floor pending-call maps
//   overflow                        : sticky, a new call was lost to a full FIFO
module call_request_gen
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = 8,
    parameter int SAMPLE_DIV   = 4,
    parameter int PRESS_THRESH = 4,
    parameter int DEPTH        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [11:0]           randy,
    input  logic                  enable,
    output logic                  req_valid,
    output logic [3:0]            req_floor,
    output logic                  req_dir,
    input  logic                  req_ready,
    input  logic                  svc_valid,
    input  logic [3:0]            svc_floor,
    input  logic                  svc_dir,
    output logic [NUM_FLOORS-1:0] pending_up,
    output logic [NUM_FLOORS-1:0] pending_dn,
    output logic                  overflow
);
    localparam int CW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
    logic [CW-1:0]      cnt;
    logic               tick;
    logic [FLOOR_W-1:0] floor;
    logic               press;
    logic               in_range;
    dir_t               dir;
    logic [15:0]        up_ext;
    logic [15:0]        dn_ext;
    logic               dup;
    logic               cand;
    logic               pop;
    logic               accept;
    logic               drop;
    logic               full;
    logic               empty;
    logic               svc_ok;
    logic [15:0]        set_vec;
    logic [15:0]        clr_vec;
    logic [15:0]        up_nx;
    logic [15:0]        dn_nx;
    logic               unused_bits;
    call_t              head;
    assign tick     = enable && cnt == CW'(SAMPLE_DIV - 1);
    assign floor    = randy[7:4];
    assign press    = {1'b0, randy[11:8]} < 5'(PRESS_THRESH);
    assign in_range = {1'b0, floor} < 5'(NUM_FLOORS);
    // End floors only have one hall button, so their direction is fixed.
    assign dir      = floor == '0 ? DIR_UP
                    : floor == FLOOR_W'(NUM_FLOORS - 1) ? DIR_DN
                    : dir_t'(randy[0]);
    assign unused_bits = ^randy[3:1];
    // Maps widened to 16 bits so any 4-bit floor can index them safely.
    assign up_ext   = 16'(pending_up);
    assign dn_ext   = 16'(pending_dn);
    assign dup      = dir == DIR_DN ? dn_ext[floor] : up_ext[floor];
    assign cand     = tick && press && in_range && !dup;
    assign pop      = req_valid && req_ready;
    assign accept   = cand && (!full || pop);
    assign drop     = cand && full && !pop;
    assign svc_ok   = svc_valid && {1'b0, svc_floor} < 5'(NUM_FLOORS);
    assign set_vec  = accept ? 16'(1) << floor : 16'h0;
    assign clr_vec  = svc_ok ? 16'(1) << svc_floor : 16'h0;
    // Set is OR-ed after the clear so a same-cycle accept wins over service.
    assign up_nx    = (up_ext & ~(!svc_dir ? clr_vec : 16'h0)) | (dir == DIR_UP ? set_vec : 16'h0);
    assign dn_nx    = (dn_ext & ~(svc_dir ? clr_vec : 16'h0)) | (dir == DIR_DN ? set_vec : 16'h0);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            pending_up <= '0;
            pending_dn <= '0;
            overflow   <= 1'b0;
        end else begin
            if (enable) cnt <= tick ? '0 : cnt + 1'b1;
            pending_up <= NUM_FLOORS'(up_nx);
            pending_dn <= NUM_FLOORS'(dn_nx);
            if (drop) overflow <= 1'b1;
        end
    end
    call_fifo #(.DEPTH(DEPTH), .T(call_t)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   ('{floor: floor, dir: dir}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    assign req_valid = !empty;
    assign req_floor = head.floor;
    assign req_dir   = head.dir;
endmodule

// File: tb/tb_call_request_gen.sv
// tb_call_request_gen: directed scenarios with a queue scoreboard of expected calls.
module tb_call_request_gen;
    localparam int SAMPLE_DIV = 4;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] randy;
    logic        enable;
    logic        req_valid;
    logic [3:0]  req_floor;
    logic        req_dir;
    logic        req_ready;
    logic        svc_valid;
    logic [3:0]  svc_floor;
    logic        svc_dir;
    logic [7:0]  pending_up;
    logic [7:0]  pending_dn;
    logic        overflow;
    int          errors = 0;
    int          checks = 0;
    logic [4:0]  exp_q[$];
    logic [4:0]  exp_call;

    call_request_gen #(.NUM_FLOORS(8), .SAMPLE_DIV(SAMPLE_DIV), .PRESS_THRESH(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .randy(randy), .enable(enable),
        .req_valid(req_valid), .req_floor(req_floor), .req_dir(req_dir), .req_ready(req_ready),
        .svc_valid(svc_valid), .svc_floor(svc_floor), .svc_dir(svc_dir),
        .pending_up(pending_up), .pending_dn(pending_dn), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Holding a word for SAMPLE_DIV enabled cycles yields exactly one tick.
    task automatic present(input logic [11:0] v);
        randy  = v;
        enable = 1'b1;
        cyc(SAMPLE_DIV);
        enable = 1'b0;
    endtask

    // Every handshake must match the oldest expected call.
    always @(negedge clk) begin
        if (!rst && req_valid && req_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL pop_unexpected got=%0h exp=none", {req_floor, req_dir});
            end else begin
                exp_call = exp_q.pop_front();
                assert ({req_floor, req_dir} === exp_call) else begin
                    errors++;
                    $error("FAIL pop_order got=%0h exp=%0h", {req_floor, req_dir}, exp_call);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; randy = '0; enable = 1'b0; req_ready = 1'b0;
        svc_valid = 1'b0; svc_floor = '0; svc_dir = 1'b0;
        cyc(2);
        check("rst_valid", req_valid, 0);
        check("rst_pend_up", pending_up, 0);
        check("rst_pend_dn", pending_dn, 0);
        check("rst_ovf", overflow, 0);

        // Single press floor 5 down, latency and dedup.
        rst = 1'b0; randy = 12'h251; enable = 1'b1; req_ready = 1'b1;
        exp_q.push_back({4'd5, 1'b1});
        cyc(3);
        check("t2_pre_valid", req_valid, 0);
        check("t2_pre_pend", pending_dn, 0);
        cyc(1);
        check("t2_valid", req_valid, 1);
        check("t2_pend_dn", pending_dn, 8'h20);
        cyc(1);
        check("t2_popped", req_valid, 0);
        cyc(8);
        check("t2_dedup_valid", req_valid, 0);
        check("t2_dedup_pend", pending_dn, 8'h20);
        enable = 1'b0;

        // Out-of-range floor and no-press word.
        present(12'h0F0);
        present(12'h851);
        cyc(2);
        check("t3_valid", req_valid, 0);
        check("t3_pend_up", pending_up, 0);
        check("t3_pend_dn", pending_dn, 8'h20);

        // Forced directions at the end floors.
        exp_q.push_back({4'd0, 1'b0});
        present(12'h001);
        exp_q.push_back({4'd7, 1'b1});
        present(12'h170);
        cyc(2);
        check("t4_pend_up", pending_up, 8'h01);
        check("t4_pend_dn", pending_dn, 8'hA0);
        check("t4_drained", exp_q.size(), 0);

        svc_valid = 1'b1; svc_floor = 4'd5; svc_dir = 1'b1; cyc(1);
        svc_floor = 4'd0; svc_dir = 1'b0; cyc(1);
        svc_floor = 4'd7; svc_dir = 1'b1; cyc(1);
        svc_valid = 1'b0; cyc(1);
        check("svc_pend_up", pending_up, 0);
        check("svc_pend_dn", pending_dn, 0);

        // Fill the FIFO with req_ready low, fifth call overflows.
        req_ready = 1'b0;
        for (int f = 1; f <= 4; f++) begin
            exp_q.push_back({4'(f), 1'b0});
            present({4'h0, 4'(f), 4'h0});
            check("t5_head_valid", req_valid, 1);
            check("t5_head_floor", req_floor, 1);
        end
        check("t5_ovf_before", overflow, 0);
        present(12'h050);
        check("t5_ovf", overflow, 1);
        check("t5_pend_up", pending_up, 8'h1E);
        check("t5_head_hold", req_floor, 1);
        req_ready = 1'b1;
        cyc(6);
        check("t5_empty", req_valid, 0);
        check("t5_drained", exp_q.size(), 0);

        // Reset mid-run with three calls queued.
        rst = 1'b1; cyc(1); rst = 1'b0; exp_q.delete();
        req_ready = 1'b0;
        present(12'h010);
        present(12'h020);
        present(12'h030);
        check("t1_pend_up", pending_up, 8'h0E);
        check("t1_valid", req_valid, 1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("t1_async_valid", req_valid, 0);
        check("t1_async_floor", req_floor, 0);
        check("t1_async_dir", req_dir, 0);
        check("t1_async_up", pending_up, 0);
        check("t1_async_dn", pending_dn, 0);
        check("t1_async_ovf", overflow, 0);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        check("t1_next_valid", req_valid, 0);

        // Service and accept of floor 5 down in the same cycle.
        randy = 12'h251; enable = 1'b1;
        exp_q.push_back({4'd5, 1'b1});
        cyc(3);
        svc_valid = 1'b1; svc_floor = 4'd5; svc_dir = 1'b1;
        cyc(1);
        enable = 1'b0; svc_floor = 4'hF;
        check("t6_set_wins", pending_dn, 8'h20);
        check("t6_queued", req_valid, 1);
        cyc(1);
        check("t6_svc_f_ignored", pending_dn, 8'h20);
        svc_floor = 4'd5;
        cyc(1);
        svc_valid = 1'b0;
        check("t6_svc_clear", pending_dn, 0);
        req_ready = 1'b1;
        cyc(3);
        check("t6_empty", req_valid, 0);
        check("t6_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
